period_meter: RTL and testbench
===============================

PERIOD_METER -- requirements
Module: period_meter

Interface
REQ-001 SHALL have parameter WIDTH, default 16, setting the width of the period counter and period outputs (legal values 8..32).
REQ-002 SHALL have parameter AVG_LOG2, default 2, which averages over 2^AVG_LOG2 periods (legal values 0..4).
REQ-003 SHALL have parameter LOCK_CNT, default 3, setting the number of consecutive in-band periods needed to assert locked (legal values 1..15).
REQ-004 Ports, in order: clk, input, 1 bit, the single clock; reset, input, 1 bit, synchronous active-high reset.
REQ-005 si, input, 1 bit, asynchronous pulse input.
REQ-006 min_prd, input, WIDTH bits, inclusive lower band limit in clk cycles; max_prd, input, WIDTH bits, inclusive upper band limit in clk cycles.
REQ-007 done_tick, output, 1 bit, one-cycle strobe marking a valid new period; prd, output, WIDTH bits, last measured period.
REQ-008 avg_tick, output, 1 bit, one-cycle strobe marking a new average; avg_prd, output, WIDTH bits, averaged period.
REQ-009 in_band, output, 1 bit, true when the last period lies inside the band; locked, output, 1 bit, band lock; timeout, output, 1 bit, counter saturated.

Function
REQ-010 si SHALL pass through a 2-flop synchronizer plus one history flop; a rising edge is the synchronized value at 1 with the history flop at 0.
REQ-011 Latency SHALL be as follows: done_tick is high in the cycle after the 3rd clk edge at which si is sampled high following a low sample.
REQ-012 The FSM states SHALL be IDLE, MEAS and TMO.
- IDLE --edge--> MEAS.
- MEAS --edge--> MEAS, with a period emitted.
- MEAS --counter saturated--> TMO.
- TMO --edge--> MEAS, with no period emitted.
REQ-013 On each edge, the counter SHALL load 1; otherwise it increments by 1 each cycle, saturating at 2^WIDTH-1.
- Period = number of clk cycles between consecutive synchronized rising edges.
- Example: si period of 10 clk gives prd = 10.
REQ-014 On an edge in MEAS, the block SHALL register prd = counter value and in_band = (min_prd <= prd <= max_prd), and pulse done_tick for exactly 1 cycle.
REQ-015 The first edge after IDLE or TMO SHALL only start counting: no done_tick, and prd, in_band and locked are unchanged.
REQ-016 When the counter reaches 2^WIDTH-1 in MEAS, the next cycle SHALL show state TMO with timeout=1, in_band=0 and locked=0; prd is held.
REQ-017 timeout SHALL clear in the cycle after the edge that leaves TMO.
REQ-018 locked SHALL assert together with the done_tick of the LOCK_CNT-th consecutive in-band period.
- locked deasserts with the first out-of-band done_tick.
- The in-band run count saturates at LOCK_CNT.
REQ-019 If min_prd > max_prd, in_band and locked SHALL never assert.
REQ-020 min_prd and max_prd SHALL be sampled only in the done_tick update cycle; changing them has no other effect.
REQ-021 Edges closer together than 2 cycles are unresolvable by the synchronizer and SHALL NOT be required to be counted.

Reset
REQ-022 When reset=1 at a clk edge, the block SHALL enter IDLE and clear the counter, prd, avg_prd, the accumulator, the run count, done_tick, avg_tick, in_band, locked, timeout and all synchronizer flops to 0.
REQ-023 Reset mid-period SHALL discard the partial period; the first edge after reset behaves as in REQ-015.

Configuration
REQ-024 The macro PERIOD_METER_AVG_EN SHALL control the averaging feature.
REQ-025 With PERIOD_METER_AVG_EN defined, the block SHALL average as follows.
- A WIDTH+AVG_LOG2-bit accumulator sums 2^AVG_LOG2 consecutive periods.
- On the done_tick completing the set, avg_prd = sum >> AVG_LOG2 (truncated) and avg_tick pulses in the same cycle as done_tick.
- The accumulator and set count then restart.
- Entry into TMO clears the accumulator and set count.
REQ-026 Without PERIOD_METER_AVG_EN, avg_prd SHALL equal prd and avg_tick SHALL equal done_tick, with no accumulator logic; the ports still exist.

Structure
REQ-027 The package period_meter_pkg SHALL hold the state enum (IDLE, MEAS, TMO) and the parameter range-limit constants.
REQ-028 The synchronizer and edge detector SHALL be the sub-module edge_sync (ports clk, reset, d_in, rise), instantiated once.

Verification
REQ-029 Default params, si period 10 clk, 50% duty -> first done_tick 10 clk after the 2nd edge's done-equivalent, then prd=10 repeatedly; no tick on the 1st edge.
REQ-030 min_prd=8, max_prd=12, periods 10,10,10,20 -> in_band=1,1,1,0; locked rises on the 3rd tick and falls on the 4th.
REQ-031 WIDTH=8, si held low after one period of 10 -> timeout=1 about 255 cycles after the last edge; the next edge clears timeout with no done_tick; the following period is reported correctly.
REQ-032 PERIOD_METER_AVG_EN defined, AVG_LOG2=2, periods 10,11,12,14 -> avg_tick once with avg_prd=11; undefined -> avg_prd tracks prd on each done_tick.
REQ-033 Reset asserted mid-period with locked=1 -> all outputs 0 next cycle; the next two edges produce exactly one done_tick.
REQ-034 min_prd=12, max_prd=8, period 10 -> in_band=0 and locked=0 throughout.

Source files
------------

// File: rtl/period_meter_pkg.sv
// Shared types and parameter limits for the period meter.
package period_meter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MEAS = 2'd1,
    TMO  = 2'd2
  } state_t;

  localparam int WIDTH_MIN    = 8;
  localparam int WIDTH_MAX    = 32;
  localparam int AVG_LOG2_MIN = 0;
  localparam int AVG_LOG2_MAX = 4;
  localparam int LOCK_CNT_MIN = 1;
  localparam int LOCK_CNT_MAX = 15;

  // Wide enough to hold any legal LOCK_CNT.
  localparam int RUN_W = 4;

  function automatic logic in_range(input int v, input int lo, input int hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/edge_sync.sv
// Two-flop synchronizer plus history flop; rise marks a synchronized 0->1.
module edge_sync (
  input  logic clk,
  input  logic reset,
  input  logic d_in,
  output logic rise
);

  logic sync1;
  logic sync2;
  logic hist;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      hist  <= 1'b0;
    end else begin
      sync1 <= d_in;
      sync2 <= sync1;
      hist  <= sync2;
    end
  end

  assign rise = sync2 & ~hist;

endmodule

// File: rtl/period_meter.sv
// Measures the period of si in clk cycles with band check, lock and timeout.
// Averaging over 2^AVG_LOG2 periods is built only when PERIOD_METER_AVG_EN is defined.
//
// state | meaning
// IDLE  | no edge seen since reset
// MEAS  | counting cycles since the last edge
// TMO   | counter saturated, waiting for an edge to restart
module period_meter
  import period_meter_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int AVG_LOG2 = 2,
  parameter int LOCK_CNT = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             si,
  input  logic [WIDTH-1:0] min_prd,
  input  logic [WIDTH-1:0] max_prd,
  output logic             done_tick,
  output logic [WIDTH-1:0] prd,
  output logic             avg_tick,
  output logic [WIDTH-1:0] avg_prd,
  output logic             in_band,
  output logic             locked,
  output logic             timeout
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;
  localparam logic [RUN_W-1:0] RUN_TGT = RUN_W'(LOCK_CNT);

  generate
    if (!in_range(WIDTH, WIDTH_MIN, WIDTH_MAX) ||
        !in_range(AVG_LOG2, AVG_LOG2_MIN, AVG_LOG2_MAX) ||
        !in_range(LOCK_CNT, LOCK_CNT_MIN, LOCK_CNT_MAX)) begin : g_param_err
      $error("period_meter: parameter out of legal range");
    end
  endgenerate

  state_t           state;
  state_t           state_nxt;
  logic             rise;
  logic [WIDTH-1:0] cnt;
  logic             emit;
  logic             enter_tmo;
  logic             prd_ok;
  logic [RUN_W-1:0] run;
  logic [RUN_W-1:0] run_inc;

  edge_sync u_edge_sync (
    .clk   (clk),
    .reset (reset),
    .d_in  (si),
    .rise  (rise)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (rise) state_nxt = MEAS;
      MEAS:    if (!rise && (cnt == CNT_MAX)) state_nxt = TMO;
      TMO:     if (rise) state_nxt = MEAS;
      default: state_nxt = IDLE;
    endcase
  end

  // Only an edge while measuring closes a period; IDLE/TMO edges just restart.
  always_comb begin
    emit      = 1'b0;
    enter_tmo = 1'b0;
    case (state)
      MEAS: begin
        emit      = rise;
        enter_tmo = !rise && (cnt == CNT_MAX);
      end
      default: ;
    endcase
  end

  assign prd_ok  = (min_prd <= cnt) && (cnt <= max_prd);
  assign run_inc = (run == RUN_TGT) ? run : run + 1'b1;

  always_ff @(posedge clk) begin
    if (reset)                                cnt <= '0;
    else if (rise)                            cnt <= WIDTH'(1);
    else if ((state == MEAS) && (cnt != CNT_MAX)) cnt <= cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      done_tick <= 1'b0;
      prd       <= '0;
      in_band   <= 1'b0;
      locked    <= 1'b0;
      timeout   <= 1'b0;
      run       <= '0;
    end else begin
      done_tick <= emit;
      if (emit) begin
        prd     <= cnt;
        in_band <= prd_ok;
        if (prd_ok) begin
          run    <= run_inc;
          locked <= (run_inc == RUN_TGT);
        end else begin
          run    <= '0;
          locked <= 1'b0;
        end
      end else if (enter_tmo) begin
        timeout <= 1'b1;
        in_band <= 1'b0;
        locked  <= 1'b0;
        run     <= '0;
      end else if ((state == TMO) && rise) begin
        timeout <= 1'b0;
      end
    end
  end

`ifdef PERIOD_METER_AVG_EN
  localparam int ACC_W = WIDTH + AVG_LOG2;
  localparam int SET_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [SET_W-1:0] SET_LAST = SET_W'((1 << AVG_LOG2) - 1);

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_sum;
  logic [SET_W-1:0] set_cnt;

  assign acc_sum = acc + ACC_W'(cnt);

  always_ff @(posedge clk) begin
    if (reset) begin
      acc      <= '0;
      set_cnt  <= '0;
      avg_prd  <= '0;
      avg_tick <= 1'b0;
    end else begin
      avg_tick <= 1'b0;
      if (emit) begin
        if (set_cnt == SET_LAST) begin
          avg_prd  <= WIDTH'(acc_sum >> AVG_LOG2);
          avg_tick <= 1'b1;
          acc      <= '0;
          set_cnt  <= '0;
        end else begin
          acc     <= acc_sum;
          set_cnt <= set_cnt + 1'b1;
        end
      end else if (enter_tmo) begin
        acc     <= '0;
        set_cnt <= '0;
      end
    end
  end
`else
  assign avg_prd  = prd;
  assign avg_tick = done_tick;
`endif

endmodule

// File: tb/tb_period_meter.sv
// Directed and randomized period stimulus checked against an edge-level reference model.
module tb_period_meter;

  localparam int W  = 8;
  localparam int AL = 2;
  localparam int LC = 3;

  logic         clk = 1'b0;
  logic         reset;
  logic         si;
  logic [W-1:0] min_prd;
  logic [W-1:0] max_prd;
  logic         done_tick;
  logic [W-1:0] prd;
  logic         avg_tick;
  logic [W-1:0] avg_prd;
  logic         in_band;
  logic         locked;
  logic         timeout;

  period_meter #(.WIDTH(W), .AVG_LOG2(AL), .LOCK_CNT(LC)) dut (
    .clk       (clk),
    .reset     (reset),
    .si        (si),
    .min_prd   (min_prd),
    .max_prd   (max_prd),
    .done_tick (done_tick),
    .prd       (prd),
    .avg_tick  (avg_tick),
    .avg_prd   (avg_prd),
    .in_band   (in_band),
    .locked    (locked),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    int prd;
    int inb;
    int lck;
    int avt;
    int avg;
    int lat;
  } ev_t;

  ev_t exp_q[$];
  ev_t act_q[$];

  int n_cmp = 0;
  int n_mis = 0;
  int cyc = 0;
  int rise_cyc = 0;
  int last_tick_cyc = 0;
  int tmo_cyc = 0;
  int stray_avg = 0;
  bit prev_tmo = 1'b0;

  // Reference model state: one entry per synchronized edge.
  bit fresh;
  bit exp_tmo;
  int prev_len;
  int run;
  int acc_sum;
  int acc_n;
  int last_prd;
  int last_avg;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    ev_t e;
    if (done_tick === 1'b1) begin
      e.prd = int'(prd);
      e.inb = int'(in_band);
      e.lck = int'(locked);
      e.avt = int'(avg_tick);
      e.avg = int'(avg_prd);
      e.lat = cyc - rise_cyc;
      act_q.push_back(e);
      last_tick_cyc = cyc;
    end
    if (avg_tick === 1'b1 && done_tick !== 1'b1) stray_avg++;
    if (timeout === 1'b1 && !prev_tmo) tmo_cyc = cyc;
    prev_tmo = (timeout === 1'b1);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_mis++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    fresh    = 1'b1;
    exp_tmo  = 1'b0;
    prev_len = 0;
    run      = 0;
    acc_sum  = 0;
    acc_n    = 0;
    last_prd = 0;
    last_avg = 0;
  endtask

  task automatic model_edge();
    ev_t e;
    int  p;
    if (!fresh) begin
      p     = prev_len;
      e.prd = p;
      e.inb = (int'(min_prd) <= p && p <= int'(max_prd)) ? 1 : 0;
      run   = e.inb ? ((run < LC) ? run + 1 : LC) : 0;
      e.lck = (run >= LC) ? 1 : 0;
`ifdef PERIOD_METER_AVG_EN
      acc_sum += p;
      acc_n++;
      if (acc_n == (1 << AL)) begin
        last_avg = acc_sum / (1 << AL);
        e.avt    = 1;
        acc_sum  = 0;
        acc_n    = 0;
      end else begin
        e.avt = 0;
      end
`else
      last_avg = p;
      e.avt    = 1;
`endif
      e.avg    = last_avg;
      e.lat    = 3;
      last_prd = p;
      exp_q.push_back(e);
    end
    fresh   = 1'b0;
    exp_tmo = 1'b0;
  endtask

  // Called on a negedge; leaves off on a negedge p cycles later.
  task automatic pulse(input int p);
    model_edge();
    si       = 1'b1;
    rise_cyc = cyc;
    repeat (p / 2) @(negedge clk);
    si = 1'b0;
    repeat (p - p / 2) @(negedge clk);
    prev_len = p;
  endtask

  task automatic hold_low(input int n);
    repeat (n) @(negedge clk);
    prev_len += n;
    if (!fresh && prev_len > 255) begin
      fresh   = 1'b1;
      exp_tmo = 1'b1;
      run     = 0;
      acc_sum = 0;
      acc_n   = 0;
    end
  endtask

  task automatic compare_q(input string tag);
    check($sformatf("%s count", tag), act_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
      check($sformatf("%s[%0d] prd", tag, i), act_q[i].prd, exp_q[i].prd);
      check($sformatf("%s[%0d] in_band", tag, i), act_q[i].inb, exp_q[i].inb);
      check($sformatf("%s[%0d] locked", tag, i), act_q[i].lck, exp_q[i].lck);
      check($sformatf("%s[%0d] avg_tick", tag, i), act_q[i].avt, exp_q[i].avt);
      check($sformatf("%s[%0d] avg_prd", tag, i), act_q[i].avg, exp_q[i].avg);
      check($sformatf("%s[%0d] latency", tag, i), act_q[i].lat, exp_q[i].lat);
    end
    act_q.delete();
    exp_q.delete();
  endtask

  task automatic check_zero(input string tag);
    check({tag, " done_tick"}, done_tick, 0);
    check({tag, " prd"}, prd, 0);
    check({tag, " avg_tick"}, avg_tick, 0);
    check({tag, " avg_prd"}, avg_prd, 0);
    check({tag, " in_band"}, in_band, 0);
    check({tag, " locked"}, locked, 0);
    check({tag, " timeout"}, timeout, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset   = 1'b1;
    si      = 1'b0;
    min_prd = 8'd8;
    max_prd = 8'd12;
    model_reset();
    repeat (3) @(negedge clk);
    check_zero("reset");
    reset = 1'b0;
    @(negedge clk);

    // Steady 10-cycle period, then band/lock sequence 10,10,10,20.
    pulse(10);
    check("first edge no tick", act_q.size(), 0);
    pulse(10);
    pulse(10);
    pulse(10);
    pulse(20);
    pulse(10);
    compare_q("band");

    // Timeout after long low, then recovery.
    hold_low(300);
    check("tmo timeout", timeout, exp_tmo);
    check("tmo in_band", in_band, 0);
    check("tmo locked", locked, 0);
    check("tmo prd held", prd, last_prd);
    check("tmo delay", tmo_cyc - last_tick_cyc, 255);
    compare_q("tmo");
    pulse(10);
    check("tmo cleared", timeout, exp_tmo);
    check("tmo exit no tick", act_q.size(), 0);

    // Averaging set 10,11,12,14.
    pulse(11);
    pulse(12);
    pulse(14);
    pulse(10);
    compare_q("avg");

    // Lock up, then reset mid-period.
    pulse(10);
    pulse(10);
    pulse(10);
    model_edge();
    si       = 1'b1;
    rise_cyc = cyc;
    repeat (5) @(negedge clk);
    compare_q("prelock");
    check("locked before reset", locked, (run >= LC) ? 1 : 0);
    reset = 1'b1;
    @(negedge clk);
    check_zero("midrst");
    reset = 1'b0;
    si    = 1'b0;
    model_reset();
    @(negedge clk);
    pulse(9);
    pulse(9);
    compare_q("post reset");

    // Inverted band never locks.
    min_prd = 8'd12;
    max_prd = 8'd8;
    for (int i = 0; i < 5; i++) pulse(10);
    compare_q("inverted band");
    check("inverted in_band", in_band, 0);
    check("inverted locked", locked, 0);

    // Randomized periods and bands.
    for (int r = 0; r < 4; r++) begin
      min_prd = 8'($urandom_range(4, 30));
      max_prd = (r == 3) ? min_prd - 8'd2 : min_prd + 8'($urandom_range(0, 15));
      for (int i = 0; i < 12; i++) begin
        if ($urandom_range(0, 2) == 0) pulse(int'(min_prd) + $urandom_range(0, 4));
        else pulse($urandom_range(4, 40));
      end
      compare_q($sformatf("rand%0d", r));
    end

    check("stray avg_tick", stray_avg, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
